// File: rtl/axis_cic_interp_ctrl.sv
// Sequencer for the CIC interpolation chain: fetches one upstream sample per R clocks,
// drives comb/ZOH/integrator enables, and runs the start/drain/flush life cycle.
module axis_cic_interp_ctrl #(
    parameter int RATE_WIDTH    = 16,
    parameter int R_DEFAULT     = 100,
    parameter int DRAIN_SAMPLES = 2
) (
    input  logic                  aclk,
    input  logic                  arst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [RATE_WIDTH-1:0] cfg_rate,
    input  logic                  cfg_rate_valid,
    output logic                  cfg_rate_ready,
    input  logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tready,
    output logic                  smp_stb,
    output logic                  smp_zero,
    output logic                  zoh_load,
    output logic                  int_en,
    output logic                  int_clr,
    output logic                  busy,
    output logic                  underrun,
    output logic [RATE_WIDTH-1:0] active_rate
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

    localparam int DCNT_W = (DRAIN_SAMPLES > 1) ? $clog2(DRAIN_SAMPLES) : 1;
    localparam logic [DCNT_W-1:0]     DRAIN_LAST = DCNT_W'(DRAIN_SAMPLES - 1);
    localparam logic [RATE_WIDTH-1:0] RATE_ONE   = RATE_WIDTH'(1);

    function automatic logic [RATE_WIDTH-1:0] clamp_rate(input logic [RATE_WIDTH-1:0] r);
        return (r == '0) ? RATE_ONE : r;
    endfunction

    state_t                state_q, state_d;
    logic [RATE_WIDTH-1:0] ph_q, ph_d;
    logic [RATE_WIDTH-1:0] active_rate_q, active_rate_d;
    logic [RATE_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic                  stop_req_q, stop_req_d;
    logic [DCNT_W-1:0]     drain_cnt_q, drain_cnt_d;
    logic                  underrun_q, underrun_d;
    logic                  rdy_q, rdy_d;
    logic                  tready_q, tready_d;
    logic                  smp_stb_q, smp_stb_d;
    logic                  smp_zero_q, smp_zero_d;
    logic                  zoh_load_q, zoh_load_d;
    logic                  int_en_q, int_en_d;
    logic                  int_clr_q, int_clr_d;
    logic                  busy_q, busy_d;

    logic wrap;
    logic apply_ok;

    assign wrap = (ph_q == active_rate_q - RATE_ONE);

    always_comb begin
        state_d       = state_q;
        ph_d          = ph_q;
        active_rate_d = active_rate_q;
        pend_d        = pend_q;
        pend_vld_d    = pend_vld_q;
        stop_req_d    = stop_req_q;
        drain_cnt_d   = drain_cnt_q;
        underrun_d    = underrun_q;
        rdy_d         = rdy_q;
        smp_stb_d     = 1'b0;
        smp_zero_d    = 1'b0;
        apply_ok      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ph_d        = '0;
                stop_req_d  = 1'b0;
                drain_cnt_d = '0;
                apply_ok    = 1'b1;
                if (start) begin
                    state_d    = S_RUN;
                    underrun_d = 1'b0;
                end
            end
            S_RUN: begin
                ph_d = wrap ? '0 : ph_q + RATE_ONE;
                if (stop) stop_req_d = 1'b1;
                // the tready cycle is the sample slot; the comb sees it one clock later
                if (tready_q) begin
                    smp_stb_d = 1'b1;
                    if (!s_axis_data_tvalid) begin
                        smp_zero_d = 1'b1;
                        underrun_d = 1'b1;
                    end
                end
                if (wrap) begin
                    apply_ok = 1'b1;
                    if (stop || stop_req_q) begin
                        state_d     = S_DRAIN;
                        stop_req_d  = 1'b0;
                        drain_cnt_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                ph_d = wrap ? '0 : ph_q + RATE_ONE;
                if (ph_q == '0) begin
                    smp_stb_d  = 1'b1;
                    smp_zero_d = 1'b1;
                end
                if (wrap) begin
                    apply_ok = 1'b1;
                    if (drain_cnt_q == DRAIN_LAST) state_d = S_FLUSH;
                    else drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                end
            end
            S_FLUSH: begin
                ph_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // a pending rate only lands on a period boundary (or at once when idle)
        if (apply_ok && pend_vld_q) begin
            active_rate_d = pend_q;
            pend_vld_d    = 1'b0;
            rdy_d         = 1'b1;
        end
        if (cfg_rate_valid && rdy_q) begin
            pend_d     = clamp_rate(cfg_rate);
            pend_vld_d = 1'b1;
            rdy_d      = 1'b0;
        end

        tready_d   = (state_d == S_RUN) && (ph_d == '0);
        zoh_load_d = smp_stb_q;
        int_en_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
        int_clr_d  = (state_d == S_IDLE) || (state_d == S_FLUSH);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            state_q       <= S_IDLE;
            ph_q          <= '0;
            active_rate_q <= RATE_WIDTH'(R_DEFAULT);
            pend_vld_q    <= 1'b0;
            stop_req_q    <= 1'b0;
            drain_cnt_q   <= '0;
            underrun_q    <= 1'b0;
            rdy_q         <= 1'b1;
            tready_q      <= 1'b0;
            smp_stb_q     <= 1'b0;
            smp_zero_q    <= 1'b0;
            zoh_load_q    <= 1'b0;
            int_en_q      <= 1'b0;
            int_clr_q     <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ph_q          <= ph_d;
            active_rate_q <= active_rate_d;
            pend_vld_q    <= pend_vld_d;
            stop_req_q    <= stop_req_d;
            drain_cnt_q   <= drain_cnt_d;
            underrun_q    <= underrun_d;
            rdy_q         <= rdy_d;
            tready_q      <= tready_d;
            smp_stb_q     <= smp_stb_d;
            smp_zero_q    <= smp_zero_d;
            zoh_load_q    <= zoh_load_d;
            int_en_q      <= int_en_d;
            int_clr_q     <= int_clr_d;
            busy_q        <= busy_d;
        end
        pend_q <= pend_d;
    end

    assign cfg_rate_ready     = rdy_q;
    assign s_axis_data_tready = tready_q;
    assign smp_stb            = smp_stb_q;
    assign smp_zero           = smp_zero_q;
    assign zoh_load           = zoh_load_q;
    assign int_en             = int_en_q;
    assign int_clr            = int_clr_q;
    assign busy               = busy_q;
    assign underrun           = underrun_q;
    assign active_rate        = active_rate_q;

endmodule

// File: tb/tb_axis_cic_interp_ctrl.sv
// Directed bench for axis_cic_interp_ctrl: per-cycle output vectors against hand-derived
// schedules for normal run, underrun, stop/drain/flush, rate change, reset abort and R = 1.
module tb_axis_cic_interp_ctrl;

    localparam int RW = 16;

    logic          aclk = 1'b0;
    logic          arst;
    logic          start;
    logic          stop;
    logic [RW-1:0] cfg_rate;
    logic          cfg_rate_valid;
    logic          cfg_rate_ready;
    logic          s_axis_data_tvalid;
    logic          s_axis_data_tready;
    logic          smp_stb;
    logic          smp_zero;
    logic          zoh_load;
    logic          int_en;
    logic          int_clr;
    logic          busy;
    logic          underrun;
    logic [RW-1:0] active_rate;

    axis_cic_interp_ctrl #(
        .RATE_WIDTH    (RW),
        .R_DEFAULT     (100),
        .DRAIN_SAMPLES (2)
    ) dut (
        .aclk               (aclk),
        .arst               (arst),
        .start              (start),
        .stop               (stop),
        .cfg_rate           (cfg_rate),
        .cfg_rate_valid     (cfg_rate_valid),
        .cfg_rate_ready     (cfg_rate_ready),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tready (s_axis_data_tready),
        .smp_stb            (smp_stb),
        .smp_zero           (smp_zero),
        .zoh_load           (zoh_load),
        .int_en             (int_en),
        .int_clr            (int_clr),
        .busy               (busy),
        .underrun           (underrun),
        .active_rate        (active_rate)
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    // bit order: tready stb zero zoh int_en int_clr busy underrun cfg_ready
    function automatic logic [31:0] pack(input logic t, input logic s, input logic z,
                                         input logic h, input logic e, input logic c,
                                         input logic b, input logic u, input logic r);
        return {23'd0, t, s, z, h, e, c, b, u, r};
    endfunction

    function automatic logic [31:0] outs();
        return pack(s_axis_data_tready, smp_stb, smp_zero, zoh_load, int_en, int_clr,
                    busy, underrun, cfg_rate_ready);
    endfunction

    // tready schedule for the rate-change run: one 100-clock period, then 50-clock periods
    function automatic logic f2(input int k);
        if (k < 0) return 1'b0;
        return (k < 100) ? (k == 0) : (((k - 100) % 50) == 0);
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    localparam logic [31:0] RST_V = 32'h0000_0009;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic t, s, z, h, e, c, b, u, r;

        arst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_rate = '0; cfg_rate_valid = 1'b0; s_axis_data_tvalid = 1'b1;
        tick(); tick(); tick();
        check("reset outs", outs(), RST_V);
        check("reset rate", 32'(active_rate), 32'd100);
        arst = 1'b0;
        tick();
        check("idle outs", outs(), RST_V);

        // run 1: R=100, underrun slot at 5000, stop at ph 37 of the last period
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 5410; i++) begin
            t = (i < 5200) && (i % 100 == 0);
            s = (i >= 1) && (i <= 5301) && (i % 100 == 1);
            z = s && ((i == 5001) || (i >= 5201));
            h = (i >= 2) && (i <= 5302) && (i % 100 == 2);
            e = (i < 5400);
            c = (i >= 5400);
            b = (i <= 5400);
            u = (i >= 5001);
            check($sformatf("run1 c%0d", i), outs(), pack(t, s, z, h, e, c, b, u, 1'b1));
            s_axis_data_tvalid = (i != 5000);
            stop = (i == 5137);
            tick();
        end
        check("run1 rate idle", 32'(active_rate), 32'd100);

        // run 2: rate 50 requested at ph 10, then reset at ph 20 of a 50-clock period
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 220; i++) begin
            t = f2(i);
            s = f2(i - 1);
            h = f2(i - 2);
            r = !((i >= 11) && (i <= 99));
            check($sformatf("run2 c%0d", i), outs(), pack(t, s, 1'b0, h, 1'b1, 1'b0, 1'b1, 1'b0, r));
            if (i == 99)  check("run2 rate before wrap", 32'(active_rate), 32'd100);
            if (i == 100) check("run2 rate after wrap", 32'(active_rate), 32'd50);
            cfg_rate_valid = (i == 10);
            cfg_rate = 16'd50;
            arst = (i == 220);
            tick();
        end
        check("abort outs", outs(), RST_V);
        check("abort rate", 32'(active_rate), 32'd100);
        arst = 1'b0;
        cfg_rate_valid = 1'b0;

        // run 3: rate 0 clamps to 1; start+stop together; stop at i=10
        cfg_rate = '0;
        cfg_rate_valid = 1'b1;
        tick();
        cfg_rate_valid = 1'b0;
        check("r3 ready after handshake", 32'(cfg_rate_ready), 32'd0);
        tick();
        check("r3 rate clamped", 32'(active_rate), 32'd1);
        check("r3 ready after apply", 32'(cfg_rate_ready), 32'd1);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            t = (i <= 10);
            s = (i >= 1) && (i <= 13);
            z = (i == 12) || (i == 13);
            h = (i >= 2) && (i <= 14);
            e = (i <= 12);
            c = (i >= 13);
            b = (i <= 13);
            check($sformatf("run3 c%0d", i), outs(), pack(t, s, z, h, e, c, b, 1'b0, 1'b1));
            stop = (i == 10);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
